// File: rtl/mult_sm_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude multiplier: FSM state
// encodings and the iteration-counter width helper.
package mult_sm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_sm_seq_dp.sv
// Shift-add datapath: accumulator, shifted multiplicand, multiplier and iteration
// counter. Early termination when MULT_SM_EARLY_EXIT_EN is defined.
module mult_sm_seq_dp #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     x_mag_i,
  input  logic [WIDTH-1:0]     y_mag_i,
  output logic [2*WIDTH-1:0]   acc_d_o,
  output logic                 last_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, x_mag_i};
      mplier_d = y_mag_i;
      cnt_d    = CW'(WIDTH);
    end else if (step_i) begin
      acc_d    = acc_q + ({(2*WIDTH){mplier_q[0]}} & mcand_q);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Last step when the counter expires, or (early exit) when no set bits remain
  // above the one being consumed this cycle.
`ifdef MULT_SM_EARLY_EXIT_EN
  assign last_o = step_i && ((cnt_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0));
`else
  assign last_o = step_i && (cnt_q == CW'(1));
`endif

  assign acc_d_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_sm_seq.sv
// Sequential sign-magnitude multiplier with start/busy/done handshake.
// Optional build macro: MULT_SM_EARLY_EXIT_EN (data-dependent early termination).
module mult_sm_seq
  import mult_sm_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 x_sign,
  input  logic [WIDTH-1:0]     x_mag,
  input  logic                 y_sign,
  input  logic [WIDTH-1:0]     y_mag,
  output logic                 busy,
  output logic                 done,
  output logic                 z_sign,
  output logic [2*WIDTH-1:0]   z_mag
);

  localparam int CW = cnt_w(WIDTH);

  state_e             state_q;
  logic               busy_q, done_q, z_sign_q, sign_q;
  logic [2*WIDTH-1:0] z_mag_q;
  logic [2*WIDTH-1:0] acc_d;
  logic               load, step, last;

  assign load = (state_q == ST_IDLE) && start;
  assign step = (state_q == ST_CALC);

  mult_sm_seq_dp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .step_i  (step),
    .x_mag_i (x_mag),
    .y_mag_i (y_mag),
    .acc_d_o (acc_d),
    .last_o  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_sign_q <= 1'b0;
      z_mag_q  <= '0;
      sign_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sign_q  <= x_sign ^ y_sign;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (last) begin
            z_mag_q  <= acc_d;
            // A zero product is always reported as +0.
            z_sign_q <= sign_q & (|acc_d);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign z_sign = z_sign_q;
  assign z_mag  = z_mag_q;

endmodule

// File: tb/tb_mult_sm_seq.sv
// Scoreboard bench for mult_sm_seq (WIDTH=4); honours MULT_SM_EARLY_EXIT_EN.
module tb_mult_sm_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           x_sign = 1'b0, y_sign = 1'b0;
  logic [W-1:0]   x_mag = '0, y_mag = '0;
  logic           busy, done, z_sign;
  logic [2*W-1:0] z_mag;

  mult_sm_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_sign (x_sign),
    .x_mag  (x_mag),
    .y_sign (y_sign),
    .y_mag  (y_mag),
    .busy   (busy),
    .done   (done),
    .z_sign (z_sign),
    .z_mag  (z_mag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        s;
    logic [7:0]  m;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int ntests = 0, nfail = 0, ndone = 0, nexp = 0;

  function automatic int exp_lat(input logic [W-1:0] ym);
`ifdef MULT_SM_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < W; i++) if (ym[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_sign"}, {31'd0, z_sign}, {31'd0, e.s});
        chk({e.name, "_mag"},  {24'd0, z_mag},  {24'd0, e.m});
        chk({e.name, "_lat"},  cyc - e.t0,      e.lat);
      end
      ndone++;
    end
  end

  task automatic issue(input string name, input logic xs, input logic [W-1:0] xm,
                       input logic ys, input logic [W-1:0] ym,
                       input logic es, input logic [7:0] em, input int extra);
    exp_t n;
    @(negedge clk);
    rst    = 1'b0;
    x_sign = xs; x_mag = xm; y_sign = ys; y_mag = ym;
    start  = 1'b1;
    n.s = es; n.m = em; n.lat = exp_lat(ym); n.t0 = cyc + 1; n.name = name;
    q.push_back(n);
    nexp++;
    repeat (extra) begin
      @(negedge clk);
      x_sign = ~x_sign; x_mag = ~x_mag; y_mag = ~y_mag;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (ndone < nexp && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ndone < nexp) begin
      ntests++;
      nfail++;
      $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, ndone, nexp);
      ndone = nexp;
      q.delete();
    end
  endtask

  initial begin
    logic       xs, ys, es;
    logic [3:0] xm, ym;
    logic [7:0] em;

    // Reset held with start pulsed: nothing may happen.
    x_sign = 1'b1; x_mag = 4'hF; y_sign = 1'b0; y_mag = 4'hF; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_zsign",  {31'd0, z_sign}, 32'd0);
    chk("rst_zmag",   {24'd0, z_mag},  32'd0);

    // First start coincides with reset release.
    issue("p11x5", 1'b0, 4'b1011, 1'b0, 4'b0101, 1'b0, 8'b0011_0111, 0);
    wait_done("p11x5");
    issue("n10xp13", 1'b1, 4'b1010, 1'b0, 4'b1101, 1'b1, 8'b1000_0010, 0);
    wait_done("n10xp13");
    issue("n15xp15", 1'b1, 4'b1111, 1'b0, 4'b1111, 1'b1, 8'b1110_0001, 0);
    wait_done("n15xp15");
    issue("n8xn4", 1'b1, 4'b1000, 1'b1, 4'b0100, 1'b0, 8'b0010_0000, 0);
    wait_done("n8xn4");
    issue("p15xn0", 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'b0000_0000, 0);
    wait_done("p15xn0");

    // Extra start pulses during CALC must be ignored.
    issue("p6xn9", 1'b0, 4'b0110, 1'b1, 4'b1001, 1'b1, 8'b0011_0110, 3);
    wait_done("p6xn9");
    repeat (4) @(negedge clk);
    chk("extra_start_busy", {31'd0, busy}, 32'd0);
    chk("extra_start_ndone", ndone, nexp);

    // Second operation killed by reset at cycle 2: no done, outputs cleared.
    @(negedge clk);
    x_sign = 1'b1; x_mag = 4'b0111; y_sign = 1'b0; y_mag = 4'b1011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_busy",  {31'd0, busy},   32'd0);
    chk("midrst_zsign", {31'd0, z_sign}, 32'd0);
    chk("midrst_zmag",  {24'd0, z_mag},  32'd0);
    chk("midrst_ndone", ndone, nexp);

    // Early-exit vector: latency 1 with the macro, 4 without; result identical.
    issue("p10xn1", 1'b0, 4'b1010, 1'b1, 4'b0001, 1'b1, 8'b0000_1010, 0);
    wait_done("p10xn1");

    // Back-to-back sweep against a reference model.
    for (int i = 0; i < 16; i++) begin
      xs = 1'($urandom_range(0, 1));
      ys = 1'($urandom_range(0, 1));
      xm = 4'($urandom_range(0, 15));
      ym = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      em = 8'(xm) * 8'(ym);
      es = (xs ^ ys) && (em != 8'd0);
      issue("sweep", xs, xm, ys, ym, es, em, 0);
      wait_done("sweep");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
